// File: rtl/isa_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : isa_pkg
// Brief   : ISA constants, output FSM states and the long-instruction rule.
// Revision: 1.0
// ----------------------------------------------------------------------------
package isa_pkg;

  localparam int IW_DEF      = 8;
  localparam int OPW_DEF     = 4;
  localparam int FIELD_W_DEF = IW_DEF - OPW_DEF;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_VALID = 1'b1
  } ir_state_e;

  // Only the opcode MSB decides instruction length, so the caller passes that bit.
  function automatic logic is_long(input logic opcode_msb);
    return opcode_msb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : ir_fifo
// Brief   : Prefetch FIFO with pop-1/pop-2 and head/head+1 visibility.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ir_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          CLK,
  input  logic          CLB,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [1:0]    pop_i,
  output logic [W-1:0]  head_o,
  output logic [W-1:0]  head1_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_nxt;

  assign rd_nxt  = rd_ptr_q + AW'(1);
  assign head_o  = mem_q[rd_ptr_q];
  assign head1_o = mem_q[rd_nxt];
  assign count_o = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
      rd_ptr_d = rd_ptr_q + AW'(pop_i);
      wr_ptr_d = wr_ptr_q + AW'(push_i);
      count_d  = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : instr_prefetch_reg
// Brief   : Instruction register with prefetch queue and two-word instructions.
// Revision: 1.0
// ----------------------------------------------------------------------------
module instr_prefetch_reg
  import isa_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             CLB,
  input  logic             LoadIR,
  input  logic [IW-1:0]    Instruction,
  output logic             IR_Ready,
  input  logic             Flush,
  input  logic             Advance,
  output logic             IRValid,
  output logic [OPW-1:0]   Opcode,
  output logic [IW-OPW-1:0] Immediate,
  output logic [IW-OPW-1:0] RegAddress,
  output logic             IsLong,
  output logic [IW-1:0]    ExtImm
);

  localparam int FW = IW - OPW;
  localparam int CW = $clog2(DEPTH) + 1;

  ir_state_e     state_q, state_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic [FW-1:0]  imm_q, imm_d;
  logic           long_q, long_d;
  logic [IW-1:0]  ext_q, ext_d;

  logic [IW-1:0]  head_w, head1_w;
  logic [CW-1:0]  count_w;
  logic           head_long_w, head_ready_w, load_w, push_w;
  logic [1:0]     pop_w;

  assign IR_Ready     = (count_w != CW'(DEPTH));
  assign push_w       = LoadIR && IR_Ready && !Flush;
  assign head_long_w  = is_long(head_w[IW-1]);
  assign head_ready_w = head_long_w ? (count_w >= CW'(2)) : (count_w >= CW'(1));
  assign load_w       = ((state_q == S_EMPTY) || Advance) && head_ready_w;
  assign pop_w        = load_w ? (head_long_w ? 2'd2 : 2'd1) : 2'd0;

  ir_fifo #(
    .W     (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .CLB     (CLB),
    .flush_i (Flush),
    .push_i  (push_w),
    .wdata_i (Instruction),
    .pop_i   (pop_w),
    .head_o  (head_w),
    .head1_o (head1_w),
    .count_o (count_w)
  );

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    long_d   = long_q;
    ext_d    = ext_q;
    if (Flush) begin
      state_d  = S_EMPTY;
      opcode_d = '0;
      imm_d    = '0;
      long_d   = 1'b0;
      ext_d    = '0;
    end else if (load_w) begin
      state_d  = S_VALID;
      opcode_d = head_w[IW-1:FW];
      imm_d    = head_w[FW-1:0];
      long_d   = head_long_w;
      ext_d    = head_long_w ? head1_w : '0;
    end else if ((state_q == S_VALID) && Advance) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      state_q  <= S_EMPTY;
      opcode_q <= '0;
      imm_q    <= '0;
      long_q   <= 1'b0;
      ext_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      long_q   <= long_d;
      ext_q    <= ext_d;
    end
  end

  assign IRValid    = (state_q == S_VALID);
  assign Opcode     = opcode_q;
  assign Immediate  = imm_q;
  assign RegAddress = imm_q;
  assign IsLong     = long_q;
  assign ExtImm     = ext_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_instr_prefetch_reg
// Brief   : Directed plus random bench against a queue-based reference model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_instr_prefetch_reg;

  localparam int IW    = 8;
  localparam int OPW   = 4;
  localparam int DEPTH = 4;
  localparam int FW    = IW - OPW;

  logic          CLK = 1'b0;
  logic          CLB;
  logic          LoadIR;
  logic [IW-1:0] Instruction;
  logic          IR_Ready;
  logic          Flush;
  logic          Advance;
  logic          IRValid;
  logic [OPW-1:0] Opcode;
  logic [FW-1:0] Immediate;
  logic [FW-1:0] RegAddress;
  logic          IsLong;
  logic [IW-1:0] ExtImm;

  instr_prefetch_reg #(.IW(IW), .OPW(OPW), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .CLB         (CLB),
    .LoadIR      (LoadIR),
    .Instruction (Instruction),
    .IR_Ready    (IR_Ready),
    .Flush       (Flush),
    .Advance     (Advance),
    .IRValid     (IRValid),
    .Opcode      (Opcode),
    .Immediate   (Immediate),
    .RegAddress  (RegAddress),
    .IsLong      (IsLong),
    .ExtImm      (ExtImm)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: a word queue plus the presented instruction.
  logic [IW-1:0] mq[$];
  bit            m_valid;
  bit            m_known;
  logic [IW-1:0] m_first;
  logic [IW-1:0] m_ext;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_known = 1'b1;
    m_first = '0;
    m_ext   = '0;
  endtask

  task automatic model_edge(input bit ld, input logic [IW-1:0] w, input bit adv, input bit fl);
    bit rdy;
    int need;
    rdy = (mq.size() != DEPTH);
    if (fl) begin
      model_reset();
    end else begin
      need = (mq.size() > 0 && mq[0][IW-1]) ? 2 : 1;
      if ((!m_valid || adv) && mq.size() >= need) begin
        m_first = mq.pop_front();
        m_ext   = m_first[IW-1] ? mq.pop_front() : '0;
        m_valid = 1'b1;
        m_known = 1'b1;
      end else if (m_valid && adv) begin
        m_valid = 1'b0;
        m_known = 1'b0;
      end
      if (ld && rdy) mq.push_back(w);
    end
  endtask

  task automatic check_outputs();
    chk("IRValid", 32'(IRValid), 32'(m_valid));
    chk("IR_Ready", 32'(IR_Ready), 32'(mq.size() != DEPTH));
    if (m_valid || m_known) begin
      chk("Opcode", 32'(Opcode), 32'(m_first[IW-1:FW]));
      chk("Immediate", 32'(Immediate), 32'(m_first[FW-1:0]));
      chk("RegAddress", 32'(RegAddress), 32'(m_first[FW-1:0]));
      chk("IsLong", 32'(IsLong), 32'(m_first[IW-1]));
      chk("ExtImm", 32'(ExtImm), 32'(m_ext));
    end
  endtask

  task automatic cycle(input bit ld, input logic [IW-1:0] w, input bit adv, input bit fl);
    LoadIR      = ld;
    Instruction = w;
    Advance     = adv;
    Flush       = fl;
    @(posedge CLK);
    #1;
    model_edge(ld, w, adv, fl);
    check_outputs();
  endtask

  initial begin
    CLB = 1'b1; LoadIR = 1'b0; Instruction = '0; Flush = 1'b0; Advance = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_outputs();
    CLB = 1'b0;

    // Short word into empty queue.
    cycle(1, 8'h3A, 0, 0);
    chk("lat_valid0", 32'(IRValid), 32'd0);
    cycle(0, 8'h00, 0, 0);
    chk("t1_op", 32'(Opcode), 32'h3);
    chk("t1_imm", 32'(Immediate), 32'hA);
    cycle(0, 8'h00, 0, 1);

    // Long instruction with a gap before its second word.
    cycle(1, 8'h9C, 0, 0);
    cycle(0, 8'h00, 0, 0);
    chk("t2_wait", 32'(IRValid), 32'd0);
    cycle(1, 8'h55, 0, 0);
    chk("t2_wait2", 32'(IRValid), 32'd0);
    cycle(0, 8'h00, 0, 0);
    chk("t2_op", 32'(Opcode), 32'h9);
    chk("t2_ext", 32'(ExtImm), 32'h55);
    chk("t2_long", 32'(IsLong), 32'd1);
    cycle(0, 8'h00, 0, 1);

    // Fill to full with Advance low.
    for (int i = 0; i < 6; i++) cycle(1, 8'h10 + 8'(i), 0, 0);
    chk("t3_full", 32'(IR_Ready), 32'd0);
    cycle(0, 8'h00, 1, 0);
    chk("t3_ready", 32'(IR_Ready), 32'd1);
    chk("t3_op2", 32'(Immediate), 32'h1);
    cycle(0, 8'h00, 0, 1);

    // Streaming across pointer wrap.
    for (int i = 0; i < 8; i++) cycle(1, 8'h20 + 8'(i), 1, 0);
    repeat (3) cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 1);

    // Flush with queued words and a concurrent push.
    for (int i = 0; i < 4; i++) cycle(1, 8'h40 + 8'(i), 0, 0);
    cycle(1, 8'h77, 0, 1);
    chk("t5_valid", 32'(IRValid), 32'd0);
    chk("t5_op", 32'(Opcode), 32'd0);
    cycle(0, 8'h00, 0, 0);
    chk("t5_drop", 32'(IRValid), 32'd0);

    // Asynchronous reset between the words of a long instruction.
    cycle(1, 8'h3A, 0, 0);
    cycle(1, 8'hA5, 1, 0);
    #2;
    CLB = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("t6_clr", 32'(Opcode), 32'd0);
    #2;
    CLB = 1'b0;
    cycle(1, 8'h21, 0, 0);
    cycle(0, 8'h00, 0, 0);
    chk("t6_op", 32'(Opcode), 32'h2);
    chk("t6_imm", 32'(Immediate), 32'h1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 7), 8'($urandom), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_prefetch_reg.md
# instr_prefetch_reg

Parametrised instruction register with a prefetch queue and two-word instruction support. Sits between instruction memory fetch and the control-unit decoder. Fetch words are buffered in a small FIFO, and each instruction is split into opcode, immediate and register-address fields. Long instructions carry a second-word extended immediate. Instructions are presented to the decoder with a valid/advance handshake.

## Interface
Parameters:
- `IW`, 8: instruction word width.
- `OPW`, 4: opcode field width. Opcode is `Instruction[IW-1:IW-OPW]`.
- `DEPTH`, 4: prefetch FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `CLK` in 1: single clock, rising edge.
- `CLB` in 1: asynchronous, active-high reset.
- `LoadIR` in 1: fetch word valid. Pushes only when `IR_Ready` is 1.
- `Instruction` in IW: fetch word.
- `IR_Ready` out 1: FIFO not full.
- `Flush` in 1: synchronous discard of all queued and presented instructions (branch taken).
- `Advance` in 1: decoder consumes the presented instruction.
- `IRValid` out 1: output fields hold a valid instruction.
- `Opcode` out OPW: opcode field.
- `Immediate` out IW-OPW: low field of the first word.
- `RegAddress` out IW-OPW: same bits as `Immediate`.
- `IsLong` out 1: presented instruction is two-word.
- `ExtImm` out IW: second word of a long instruction; 0 for short instructions.

## Operation
- An instruction is long when the opcode MSB is 1. The word following it in the queue is its `ExtImm`.
- FIFO:
  - Push on `LoadIR && IR_Ready`.
  - `count` is `$clog2(DEPTH)+1` bits wide.
  - `IR_Ready = (count != DEPTH)`, derived from registered `count` only. A full FIFO refuses a push even in a cycle that pops.
  - Read and write pointers wrap modulo `DEPTH`.
- Output FSM states:
  - `S_EMPTY`: `IRValid=0`.
  - `S_VALID`: `IRValid=1`.
- Load condition: `load = (S_EMPTY || Advance) && head_ready`.
  - `head_ready` = `count>=1` when the head is short, `count>=2` when the head is long.
  - On load: pop 1 word (short) or 2 words (long), register all fields, go to `S_VALID`.
- `S_VALID` with `Advance` and no `head_ready`: go to `S_EMPTY`.
- `Advance` in `S_EMPTY` is ignored.
- A long head with `count==1` waits. Its opcode is not presented until the second word arrives.
- Simultaneous push and pop: `count` changes by (+1 if push) - (pops). No bypass; a word pushed at edge N is poppable at edge N+1 at the earliest.
- `Flush` has priority over everything:
  - Next edge: `count=0`, pointers 0, `S_EMPTY`, all output fields 0.
  - A `LoadIR` in the same cycle is dropped.
- Reset values: all output fields 0, `IRValid=0`, `IsLong=0`, `IR_Ready=1`, `count=0`, pointers 0.

## Timing
- Latency for a short word pushed into an empty queue with `S_EMPTY`: push at edge N, `IRValid=1` with fields after edge N+1.
- Long instruction: `IRValid` rises one edge after the edge that pushes its second word.
- Throughput: one instruction per cycle when `Advance` is held high and the queue is fed.
- `CLB` asserted mid-operation clears state immediately, independent of `CLK`. The first push is accepted on the first rising edge after deassertion.

## Structure
- Shared package `isa_pkg`:
  - `IW` and `OPW` defaults.
  - `is_long(opcode)` function.
  - Output FSM state enum.
  - Field-extraction constants.
- Sub-module `ir_fifo`:
  - Synchronous FIFO with async `CLB`.
  - Provides pop-1/pop-2 capability and exposes head and head+1 words plus `count`.
  - The top level holds the FSM and the output registers.

## Test plan
- Reset, push `8'h3A`, hold `Advance=0` → one edge later: `Opcode=3`, `Immediate=RegAddress=4'hA`, `IsLong=0`, `ExtImm=0`, `IRValid=1`.
- Push `8'h9C`, then one idle cycle, then `8'h55` → `IRValid` stays 0 until one edge after the `8'h55` push, then `Opcode=9`, `Immediate=C`, `ExtImm=8'h55`, `IsLong=1`.
- `DEPTH=4`, `Advance=0`, push 6 short words back to back:
  - Word 1 is presented and words 2–5 fill the FIFO; `IR_Ready=0` once `count=4`.
  - Word 6 is not pushed while `IR_Ready=0`.
  - After `Advance` is pulsed, `IR_Ready=1` again.
- Stream 8 short words with `Advance=1` → one instruction is retired per cycle, in order, across pointer wrap-around.
- `Flush` with 3 queued words and `LoadIR` high → next edge: `count=0`, `IRValid=0`, fields 0, and the concurrent word is dropped.
- Assert `CLB` between the two words of a long instruction → outputs clear immediately. After release, push `8'h21` → `Opcode=2`, `Immediate=1`; the stale first word is not presented.
